// File: rtl/apb_master_if.sv
// ---------------------------------------------------------------------------
// apb_master_if
//
// Purpose: bundles the command/response handshake and the APB bus signals
// of apb_master into one interface.
//
// Widths come from defines.h (DATA_WIDTH, ADDR_WIDTH); when those macros are
// not supplied by the build they default to 32 here.
//
// Modports:
//   master : view of apb_master (accepts commands, returns responses,
//            drives PSELx/PENABLE/PWRITE/PADDR/PWDATA/PSTRB, samples
//            PRDATA/PREADY/PSLVERR)
//   slave  : view of the environment (command source, response sink and
//            APB completer)
//
// Signals:
//   cmd_valid/cmd_ready, cmd_write, cmd_addr, cmd_wdata, cmd_strb
//   rsp_valid/rsp_ready, rsp_rdata, rsp_err
//   PSELx, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PRDATA, PREADY, PSLVERR
// ---------------------------------------------------------------------------
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

interface apb_master_if #(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int ADDR_WIDTH = `ADDR_WIDTH
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic [STRB_WIDTH-1:0] cmd_strb;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    logic                  PSELx;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [STRB_WIDTH-1:0] PSTRB;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output PSELx, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  PSELx, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_master.sv
// ---------------------------------------------------------------------------
// apb_master
//
// Purpose: turns single commands into APB transfers. One command is in
// flight at a time: IDLE accepts it, SETUP and ACCESS run the APB phases,
// RESP holds the result until the consumer takes it. Every output is a
// flop, so each output's next value is derived from the next state.
//
// Ports:
//   PCLK     in   clock, all state changes on the rising edge
//   PRESETn  in   asynchronous active-low reset
//   bus      apb_master_if.master: command/response handshakes + APB bus
//
// Parameters:
//   DATA_WIDTH, ADDR_WIDTH  default from defines.h macros (32 if absent)
//   TIMEOUT_CYCLES          ACCESS wait limit, only used with the watchdog
//
// Optional feature: define APB_TIMEOUT_EN to enable the ACCESS-phase
// watchdog. Without it ACCESS waits for PREADY indefinitely.
// ---------------------------------------------------------------------------
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module apb_master #(
    parameter int DATA_WIDTH     = `DATA_WIDTH,
    parameter int ADDR_WIDTH     = `ADDR_WIDTH,
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic          PCLK,
    input logic          PRESETn,
    apb_master_if.master bus
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                state;
    state_t                next_state;

    logic                  cmd_ready_q, cmd_ready_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [STRB_WIDTH-1:0] pstrb_q, pstrb_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;

    logic                  cmd_accept;
    logic                  xfer_done;
    logic                  timeout_hit;

    // cmd_ready is itself a flop, so it stays low for the first IDLE cycle
    // after reset; accepting only on the registered value keeps the
    // handshake consistent with what the requester sees.
    assign cmd_accept = (state == IDLE) && cmd_ready_q && bus.cmd_valid;
    assign xfer_done  = (state == ACCESS) && bus.PREADY;

`ifdef APB_TIMEOUT_EN
    localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_WIDTH-1:0] wait_cnt;

    // Counts consecutive ACCESS cycles without PREADY; it sits at zero in
    // every other state so each ACCESS phase starts from a clean count.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wait_cnt <= '0;
        end else if (state != ACCESS) begin
            wait_cnt <= '0;
        end else if (!bus.PREADY) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // PREADY on the final counted cycle completes the transfer normally.
    assign timeout_hit = (state == ACCESS) && !bus.PREADY &&
                         (wait_cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
`else
    localparam int timeout_cycles_unused = TIMEOUT_CYCLES;

    assign timeout_hit = 1'b0;
`endif

    // State and output flops. Reset clears everything, which also drops
    // any transfer in progress without producing a response.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state       <= IDLE;
            cmd_ready_q <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state       <= next_state;
            cmd_ready_q <= cmd_ready_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Transfer sequencing: SETUP always lasts one cycle, ACCESS ends on
    // PREADY (or the watchdog), RESP ends on the response handshake.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (cmd_accept) next_state = SETUP;
            SETUP:   next_state = ACCESS;
            ACCESS:  if (xfer_done || timeout_hit) next_state = RESP;
            RESP:    if (bus.rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Next values of the registered outputs. Control bits follow the state
    // being entered; address/data are loaded once at acceptance and then
    // held. Reads carry zero write data and strobes.
    always_comb begin
        cmd_ready_d = (next_state == IDLE);
        psel_d      = (next_state == SETUP) || (next_state == ACCESS);
        penable_d   = (next_state == ACCESS);
        rsp_valid_d = (next_state == RESP);
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pstrb_d     = pstrb_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        if (cmd_accept) begin
            pwrite_d = bus.cmd_write;
            paddr_d  = bus.cmd_addr;
            pwdata_d = bus.cmd_write ? bus.cmd_wdata : '0;
            pstrb_d  = bus.cmd_write ? bus.cmd_strb : '0;
        end

        if (xfer_done) begin
            rsp_rdata_d = pwrite_q ? '0 : bus.PRDATA;
            rsp_err_d   = bus.PSLVERR;
        end else if (timeout_hit) begin
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.PSELx     = psel_q;
    assign bus.PENABLE   = penable_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PWDATA    = pwdata_q;
    assign bus.PSTRB     = pstrb_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL take widths from defines.h: DATA_WIDTH, default 32, data/PWDATA/PRDATA width.
REQ-002 SHALL take ADDR_WIDTH from defines.h, default 32, PADDR width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, ACCESS-phase wait limit (used only under APB_TIMEOUT_EN).
REQ-004 SHALL have: one clock; reset is asynchronous and active-low (PCLK, PRESETn).
REQ-005 PCLK  in  1  clock; all state changes on rising edge.
REQ-006 PRESETn  in  1  asynchronous active-low reset.
REQ-007 cmd_valid  in  1  command request; cmd_ready  out  1  command accepted when both high.
REQ-008 cmd_write  in  1, cmd_addr  in  ADDR_WIDTH, cmd_wdata  in  DATA_WIDTH, cmd_strb  in  DATA_WIDTH/8: command fields.
REQ-009 rsp_valid  out  1  response available; rsp_ready  in  1  response consumed when both high.
REQ-010 rsp_rdata  out  DATA_WIDTH  read data (0 for writes); rsp_err  out  1  slave error or timeout.
REQ-011 PSELx, PENABLE, PWRITE  out  1; PADDR  out  ADDR_WIDTH; PWDATA  out  DATA_WIDTH; PSTRB  out  DATA_WIDTH/8.
REQ-012 PRDATA  in  DATA_WIDTH; PREADY  in  1; PSLVERR  in  1.

Function
REQ-013 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP; all outputs registered.
REQ-014 cmd_ready SHALL be 1 only in IDLE; handshake in IDLE captures all cmd fields and moves to SETUP.
REQ-015 SETUP (exactly one cycle): PSELx=1, PENABLE=0, PADDR/PWRITE/PWDATA/PSTRB driven from captured command; next state ACCESS.
REQ-016 ACCESS: PSELx=1, PENABLE=1, all address/control/data outputs held stable until PREADY=1 sampled.
REQ-017 On PREADY=1 in ACCESS: capture PRDATA (reads) or 0 (writes) into rsp_rdata, PSLVERR into rsp_err; drop PSELx/PENABLE next cycle; go to RESP.
REQ-018 PSTRB SHALL be 0 for reads; PWDATA SHALL be 0 for reads.
REQ-019 RESP: rsp_valid=1 holding rsp_rdata/rsp_err stable until rsp_ready=1; then IDLE, rsp_valid=0.
REQ-020 Minimum latency: handshake at edge N, SETUP cycle N+1, ACCESS N+2, rsp_valid=1 at N+3 with zero-wait slave.
REQ-021 SHALL not issue back-to-back transfers; PSELx=0 for at least one cycle (RESP) between transfers.
REQ-022 cmd_valid while not IDLE SHALL be ignored (cmd_ready=0); no command buffering beyond one in flight.
REQ-023 rsp_ready asserted before RESP SHALL have no effect.
REQ-024 PENABLE SHALL never be 1 while PSELx=0.

Reset
REQ-025 PRESETn=0 SHALL immediately force IDLE, PSELx=0, PENABLE=0, PWRITE=0, PADDR/PWDATA/PSTRB=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, cmd_ready=0.
REQ-026 cmd_ready SHALL rise one cycle after PRESETn deasserts.
REQ-027 Reset mid-transfer SHALL abort it with no response generated.

Configuration
REQ-028 Macro APB_TIMEOUT_EN SHALL gate an ACCESS-phase watchdog counter.
REQ-029 With APB_TIMEOUT_EN: counter clears on ACCESS entry; if PREADY=0 for TIMEOUT_CYCLES consecutive ACCESS cycles, drop PSELx/PENABLE, go RESP with rsp_err=1, rsp_rdata=0.
REQ-030 PREADY=1 on the final count cycle SHALL complete normally (PREADY wins).
REQ-031 Without APB_TIMEOUT_EN: no counter logic; ACCESS waits indefinitely for PREADY.

Verification
REQ-032 Write 0x0000_0010 data 0xDEAD_BEEF strb 0xF, PREADY=1 -> SETUP then one ACCESS cycle with those values, rsp_valid next cycle, rsp_err=0, rsp_rdata=0.
REQ-033 Read 0x0000_0004, PREADY low 3 ACCESS cycles then high with PRDATA=0x1234_5678 -> PADDR/PWRITE stable 4 ACCESS cycles, PSTRB=0, rsp_rdata=0x1234_5678.
REQ-034 Read with PSLVERR=1 at PREADY, rsp_ready held low 5 cycles -> rsp_valid/rsp_err=1 held 5 cycles, cmd_ready=0 throughout.
REQ-035 PRESETn=0 during ACCESS -> PSELx/PENABLE=0 same cycle, no rsp_valid, cmd_ready=1 one cycle after release.
REQ-036 APB_TIMEOUT_EN, TIMEOUT_CYCLES=16, PREADY held 0 -> PSELx drops after 16 ACCESS cycles, rsp_err=1, rsp_rdata=0.
REQ-037 Two commands with cmd_valid held high -> second accepted only after first rsp handshake; PSELx low at least one cycle between.
